// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the registered 8-bit ALU.
// Holds the operand width, the 3-bit opcode encodings and the
// values the output flops take while rst is high.
package alu_pkg;

  localparam int ALU_W = 8;

  // Opcode encodings, {s2,s1,s0}
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  // Output state while rst is high: zero result, so z reads 1
  localparam logic [ALU_W-1:0] F_RST = '0;
  localparam logic             C_RST = 1'b0;
  localparam logic             V_RST = 1'b0;
  localparam logic             Z_RST = 1'b1;

  // The MSB of the opcode splits arithmetic (0xx) from bitwise (1xx)
  function automatic logic is_logic_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational 8-bit adder/subtractor with a 9-bit internal sum.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a, b operands; sub selects a-b; sum result, cout raw carry-out of
// the 9-bit sum (the caller turns it into a borrow), ovf signed overflow.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sub,
  output logic [ALU_W-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [ALU_W-1:0] b_eff;
  logic [ALU_W:0]   sum_full;

  // Subtraction is a + ~b + 1; the carry-in doubles as the +1
  assign b_eff    = sub ? ~b : b;
  assign sum_full = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
  assign sum      = sum_full[ALU_W-1:0];
  assign cout     = sum_full[ALU_W];

  // Overflow when the effective operands agree in sign but the sum does not
  assign ovf = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);

endmodule

// File: rtl/alu.sv
// alu: registered 8-bit ALU (add/sub/inc/dec/and/or/xor/not) with c, v, z flags.
// Latency: 1 cycle; 2 cycles when ALU_INPUT_REG_EN is defined (input register stage).
// Backpressure: none; a new operation is accepted every cycle, no enable/handshake.
// Ports: clk, rst (sync, active-high); A, B operands; s2..s0 opcode;
// F result, c carry/borrow, v signed overflow, z zero -- all registered.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  output logic [ALU_W-1:0] F,
  output logic             c,
  output logic             v,
  output logic             z
);

  logic [ALU_W-1:0] a_q;
  logic [ALU_W-1:0] b_q;
  logic [2:0]       op_q;

`ifdef ALU_INPUT_REG_EN
  // Input stage resets to zero operands with opcode ADD, so the first
  // post-reset output is 0+0 (F=0, z=1).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else begin
      a_q  <= A;
      b_q  <= B;
      op_q <= {s2, s1, s0};
    end
  end
`else
  assign a_q  = A;
  assign b_q  = B;
  assign op_q = {s2, s1, s0};
`endif

  // One adder serves all four arithmetic ops; INC/DEC force b to 1
  logic             as_sub;
  logic [ALU_W-1:0] as_b;
  logic [ALU_W-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;

  assign as_sub = (op_q == OP_SUB) || (op_q == OP_DEC);
  assign as_b   = ((op_q == OP_INC) || (op_q == OP_DEC)) ? ALU_W'(1) : b_q;

  alu_addsub u_addsub (
    .a    (a_q),
    .b    (as_b),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  logic [ALU_W-1:0] f_nxt;
  logic             c_nxt;
  logic             v_nxt;

  always_comb begin
    f_nxt = as_sum;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    if (is_logic_op(op_q)) begin
      case (op_q)
        OP_AND:  f_nxt = a_q & b_q;
        OP_OR:   f_nxt = a_q | b_q;
        OP_XOR:  f_nxt = a_q ^ b_q;
        default: f_nxt = ~a_q;
      endcase
    end else begin
      // A subtract that produces no carry-out needed a borrow
      c_nxt = as_sub ? ~as_cout : as_cout;
      v_nxt = as_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      F <= F_RST;
      c <= C_RST;
      v <= V_RST;
      z <= Z_RST;
    end else begin
      F <= f_nxt;
      c <= c_nxt;
      v <= v_nxt;
      z <= (f_nxt == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu with hand-computed expectations.
// A new vector is driven every cycle; each result is checked LAT edges later.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B;
  logic       s2, s1, s0;
  logic [7:0] F;
  logic       c, v, z;

`ifdef ALU_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] f;
    logic       fc;
    logic       fv;
    logic       fz;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .s2  (s2),
    .s1  (s1),
    .s0  (s0),
    .F   (F),
    .c   (c),
    .v   (v),
    .z   (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%03h required 0x%03h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] f, input logic fc, input logic fv, input logic fz);
    vec_t t;
    t.a = a; t.b = b; t.op = op; t.f = f; t.fc = fc; t.fv = fv; t.fz = fz;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    A = a;
    B = b;
    {s2, s1, s0} = op;
  endtask

  initial begin
    //        A     B     op      F    c     v     z
    add_vec(8'd33, 8'd18, 3'b000, 8'd51,  1'b0, 1'b0, 1'b0);
    add_vec(8'd33, 8'd18, 3'b001, 8'd15,  1'b0, 1'b0, 1'b0);
    add_vec(8'd33, 8'd18, 3'b010, 8'd34,  1'b0, 1'b0, 1'b0);
    add_vec(8'd33, 8'd18, 3'b011, 8'd32,  1'b0, 1'b0, 1'b0);
    add_vec(8'd33, 8'd18, 3'b100, 8'd0,   1'b0, 1'b0, 1'b1);
    add_vec(8'd33, 8'd18, 3'b101, 8'd51,  1'b0, 1'b0, 1'b0);
    add_vec(8'd33, 8'd18, 3'b110, 8'd51,  1'b0, 1'b0, 1'b0);
    add_vec(8'd33, 8'd18, 3'b111, 8'd222, 1'b0, 1'b0, 1'b0);
    add_vec(8'd128, 8'd1, 3'b001, 8'd127, 1'b0, 1'b1, 1'b0);
    add_vec(8'd200, 8'd100, 3'b000, 8'd44, 1'b1, 1'b0, 1'b0);
    add_vec(8'd127, 8'd1, 3'b000, 8'd128, 1'b0, 1'b1, 1'b0);
    add_vec(8'd255, 8'd77, 3'b010, 8'd0,  1'b1, 1'b0, 1'b1);
    add_vec(8'd0,   8'd77, 3'b011, 8'd255, 1'b1, 1'b0, 1'b0);
    add_vec(8'd5,   8'd5,  3'b001, 8'd0,  1'b0, 1'b0, 1'b1);
    add_vec(8'd127, 8'd77, 3'b010, 8'd128, 1'b0, 1'b1, 1'b0);
    add_vec(8'd128, 8'd77, 3'b011, 8'd127, 1'b0, 1'b1, 1'b0);
    add_vec(8'd1,   8'd2,  3'b001, 8'd255, 1'b1, 1'b0, 1'b0);
    add_vec(8'h0f,  8'hff, 3'b111, 8'hf0, 1'b0, 1'b0, 1'b0);
    add_vec(8'hff,  8'hff, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1);
    add_vec(8'ha0,  8'h05, 3'b101, 8'ha5, 1'b0, 1'b0, 1'b0);

    // Reset with non-zero inputs present
    rst = 1'b1;
    drive(8'd33, 8'd18, 3'b000);
    @(negedge clk);
    @(negedge clk);
    check("reset_F", {3'b0, F}, 11'd0);
    check("reset_cvz", {8'b0, c, v, z}, 11'b000_0000_0001);

    // Streamed vectors: inputs change every cycle, result i seen LAT edges later
    for (int i = 0; i < vecs.size() + LAT; i++) begin
      if (i == 0) begin
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
`ifdef ALU_INPUT_REG_EN
      // First edge out of reset drains the zeroed input stage (0+0)
      if (i == 1) begin
        check("post_reset_F", {3'b0, F}, 11'd0);
        check("post_reset_cvz", {8'b0, c, v, z}, 11'b000_0000_0001);
      end
`endif
      if (i >= LAT) begin
        check($sformatf("vec%0d_F", i - LAT), {3'b0, F}, {3'b0, vecs[i-LAT].f});
        check($sformatf("vec%0d_cvz", i - LAT), {8'b0, c, v, z},
              {8'b0, vecs[i-LAT].fc, vecs[i-LAT].fv, vecs[i-LAT].fz});
      end
      if (i < vecs.size()) begin
        drive(vecs[i].a, vecs[i].b, vecs[i].op);
      end
    end

    // Reset takes priority over a carry-producing add mid-stream
    drive(8'd200, 8'd100, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_F", {3'b0, F}, 11'd0);
    check("midreset_cvz", {8'b0, c, v, z}, 11'b000_0000_0001);
    rst = 1'b0;
    for (int k = 0; k < LAT; k++) @(negedge clk);
    check("release_F", {3'b0, F}, 11'd44);
    check("release_cvz", {8'b0, c, v, z}, 11'b000_0000_0100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
